// File: rtl/axi_read_burst_issuer_pkg.sv
// Shared encodings for the read burst issuer: FSM states and AXI burst/size/resp codes.
package axi_read_burst_issuer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_FSH  = 2'd3;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  function automatic logic [2:0] axi_size(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_read_burst_issuer_if.sv
// AXI4 read address + read data channels between the issuer (master) and memory (slave).
interface axi_read_burst_issuer_if #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 256
);
  logic [ASIZE-1:0] axi_araddr;
  logic [7:0]       axi_arlen;
  logic [2:0]       axi_arsize;
  logic [1:0]       axi_arburst;
  logic             axi_arvalid;
  logic             axi_arready;
  logic [DSIZE-1:0] axi_rdata;
  logic [1:0]       axi_rresp;
  logic             axi_rlast;
  logic             axi_rvalid;
  logic             axi_rready;

  modport master (
    output axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );

  modport slave (
    input  axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/axi_read_burst_issuer_frame_addr_tracker.sv
// Frame read pointer and remaining-beat count; wraps at end of frame and reports the tail size.
module frame_addr_tracker #(
  parameter int               ASIZE       = 32,
  parameter int               LSIZE       = 9,
  parameter int               BYTES       = 32,
  parameter int               BURST_LEN   = 200,
  parameter int               FRAME_BEATS = 8100,
  parameter logic [ASIZE-1:0] BASE_ADDR   = '0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             idle,
  input  logic             fsh,
  input  logic             consume,
  input  logic [LSIZE-1:0] len,
  output logic [ASIZE-1:0] pointer,
  output logic             tail_status,
  output logic [LSIZE-1:0] tail_len
);

  localparam int RW  = $clog2(FRAME_BEATS + 1);
  localparam int BW  = $clog2(BURST_LEN + 1);
  localparam int CW0 = (RW > LSIZE) ? RW : LSIZE;
  localparam int CW  = (CW0 > BW) ? CW0 : BW;

  localparam logic [CW-1:0] FRAME_C = CW'(FRAME_BEATS);
  localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);

  logic [RW-1:0]    remaining;
  logic             pending;
  logic             restart;
  logic [CW-1:0]    rem_sub, rem_next;
  logic [ASIZE-1:0] ptr_next;
  logic             tail_next;

  // A frame_start seen mid-burst waits until the burst retires so the burst keeps its address.
  assign restart = (idle & frame_start) | (fsh & (pending | frame_start));

  always_comb begin
    rem_sub  = CW'(remaining) - CW'(len);
    ptr_next = pointer;
    rem_next = CW'(remaining);
    if (restart) begin
      ptr_next = BASE_ADDR;
      rem_next = FRAME_C;
    end else if (consume) begin
      if (rem_sub == '0) begin
        ptr_next = BASE_ADDR;
        rem_next = FRAME_C;
      end else begin
        ptr_next = pointer + ASIZE'(len) * ASIZE'(BYTES);
        rem_next = rem_sub;
      end
    end
  end

  assign tail_next = (rem_next < BURST_C);

  always_ff @(posedge clock) begin
    if (rst) begin
      pointer     <= BASE_ADDR;
      remaining   <= RW'(FRAME_BEATS);
      pending     <= 1'b0;
      tail_status <= (FRAME_C < BURST_C);
      tail_len    <= (FRAME_C < BURST_C) ? LSIZE'(FRAME_C) : '0;
    end else begin
      pointer     <= ptr_next;
      remaining   <= RW'(rem_next);
      tail_status <= tail_next;
      tail_len    <= tail_next ? LSIZE'(rem_next) : '0;
      if (restart)          pending <= 1'b0;
      else if (frame_start) pending <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_read_burst_issuer.sv
// Read-side AXI4 master: one AR burst per controller request, R beats streamed into the read FIFO.
module axi_read_burst_issuer
  import axi_read_burst_issuer_pkg::*;
#(
  parameter int               ASIZE       = 32,
  parameter int               DSIZE       = 256,
  parameter int               LSIZE       = 9,
  parameter int               BURST_LEN   = 200,
  parameter int               FRAME_BEATS = 8100,
  parameter logic [ASIZE-1:0] BASE_ADDR   = '0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  burst_req,
  input  logic                  tail_req,
  input  logic [LSIZE-1:0]      req_len,
  output logic                  resp,
  output logic                  done,
  output logic                  tail_status,
  output logic [LSIZE-1:0]      tail_len,
  axi_read_burst_issuer_if.master axi,
  output logic                  fifo_wr_en,
  output logic [DSIZE-1:0]      fifo_wdata,
  input  logic                  fifo_full,
  output logic                  err
);

  localparam int BYTES = DSIZE / 8;

  logic [1:0]       cstate;
  logic [LSIZE-1:0] len;
  logic [ASIZE-1:0] araddr;
  logic [ASIZE-1:0] pointer;
  logic [LSIZE:0]   cnt, beat_n;
  logic             req, accept, ar_hs, beat, last_exp, rready;

  assign req      = burst_req | tail_req;
  // frame_start wins over a coincident request; the request is taken next cycle at BASE_ADDR.
  assign accept   = (cstate == ST_IDLE) && req && !frame_start;
  assign ar_hs    = (cstate == ST_ADDR) && axi.axi_arready;
  assign rready   = (cstate == ST_DATA) && !fifo_full;
  assign beat     = rready && axi.axi_rvalid;
  assign beat_n   = cnt + 1'b1;
  assign last_exp = (beat_n == {1'b0, len});

  assign axi.axi_araddr  = araddr;
  assign axi.axi_arlen   = 8'(len - 1'b1);
  assign axi.axi_arsize  = axi_size(BYTES);
  assign axi.axi_arburst = AXI_BURST_INCR;
  assign axi.axi_arvalid = (cstate == ST_ADDR);
  assign axi.axi_rready  = rready;

  assign fifo_wr_en = beat;
  assign fifo_wdata = axi.axi_rdata;
  assign done       = (cstate == ST_FSH);

  always_ff @(posedge clock) begin
    if (rst) begin
      cstate <= ST_IDLE;
      len    <= '0;
      araddr <= '0;
      cnt    <= '0;
      resp   <= 1'b0;
      err    <= 1'b0;
    end else begin
      resp <= 1'b0;
      case (cstate)
        ST_IDLE: if (accept) begin
          len    <= req_len;
          araddr <= pointer;
          cnt    <= '0;
          if (req_len == '0) begin
            cstate <= ST_FSH;
            resp   <= 1'b1;
          end else begin
            cstate <= ST_ADDR;
          end
        end
        ST_ADDR: if (ar_hs) begin
          resp   <= 1'b1;
          cstate <= ST_DATA;
        end
        ST_DATA: if (beat) begin
          cnt <= beat_n;
          // rlast early, missing at beat len, or a non-OKAY beat all flag err; the burst still drains.
          if ((axi.axi_rresp != AXI_RESP_OKAY) || (axi.axi_rlast != last_exp)) err <= 1'b1;
          if (axi.axi_rlast) cstate <= ST_FSH;
        end
        default: cstate <= ST_IDLE;
      endcase
    end
  end

  frame_addr_tracker #(
    .ASIZE      (ASIZE),
    .LSIZE      (LSIZE),
    .BYTES      (BYTES),
    .BURST_LEN  (BURST_LEN),
    .FRAME_BEATS(FRAME_BEATS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_tracker (
    .clock      (clock),
    .rst        (rst),
    .frame_start(frame_start),
    .idle       (cstate == ST_IDLE),
    .fsh        (cstate == ST_FSH),
    .consume    (ar_hs),
    .len        (len),
    .pointer    (pointer),
    .tail_status(tail_status),
    .tail_len   (tail_len)
  );

endmodule

// File: tb/tb_axi_read_burst_issuer.sv
// Directed bench for axi_read_burst_issuer with a small frame (450 beats) and an address/length scoreboard.
module tb_axi_read_burst_issuer;

  localparam int          ASIZE = 32;
  localparam int          DSIZE = 256;
  localparam int          LSIZE = 9;
  localparam int          BURST = 200;
  localparam int          FRAME = 450;
  localparam int          BYTES = DSIZE / 8;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic             clock = 1'b0;
  logic             rst, frame_start, burst_req, tail_req, fifo_full;
  logic [LSIZE-1:0] req_len;
  logic             resp, done, tail_status, fifo_wr_en, err;
  logic [LSIZE-1:0] tail_len;
  logic [DSIZE-1:0] fifo_wdata;

  axi_read_burst_issuer_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) axi_bus ();

  axi_read_burst_issuer #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE), .BURST_LEN(BURST),
    .FRAME_BEATS(FRAME), .BASE_ADDR(BASE)
  ) dut (
    .clock(clock), .rst(rst), .frame_start(frame_start), .burst_req(burst_req),
    .tail_req(tail_req), .req_len(req_len), .resp(resp), .done(done),
    .tail_status(tail_status), .tail_len(tail_len), .axi(axi_bus),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_total = 0;
  int done_total = 0;

  logic [31:0] q_addr[$];
  logic [7:0]  q_arlen[$];
  logic [31:0] m_ptr;
  int          m_rem;

  always @(negedge clock) begin
    if (fifo_wr_en) wr_total <= wr_total + 1;
    if (done) done_total <= done_total + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_fs();
    m_ptr = BASE;
    m_rem = FRAME;
  endtask

  task automatic run_burst(input bit tail, input int len, input int ar_delay, input int rlast_at,
                           input int slverr_beat, input bit full_toggle, input bit fs_mid,
                           input bit fs_req, input int abort_at);
    int          nbeats, wr0, dn0, cyc, b, exp_tl, post_tl;
    bit          seen, stable, data_ok, exp_ts, post_ts;
    logic [31:0] exp_a;
    logic [7:0]  exp_l;
    if (fs_req) model_fs();
    q_addr.push_back(m_ptr);
    q_arlen.push_back(8'(len - 1));
    m_ptr = m_ptr + 32'(len * BYTES);
    m_rem = m_rem - len;
    if (m_rem == 0) model_fs();
    exp_ts = (m_rem < BURST);
    exp_tl = exp_ts ? m_rem : 0;
    if (fs_mid) model_fs();
    post_ts = (m_rem < BURST);
    post_tl = post_ts ? m_rem : 0;
    wr0 = wr_total;
    dn0 = done_total;

    burst_req = !tail; tail_req = tail; req_len = LSIZE'(len); frame_start = fs_req;
    if (fs_req) begin
      tick();
      check("fs_wins_no_arvalid", axi_bus.axi_arvalid, 1'b0);
      frame_start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = axi_bus.axi_arvalid;
    end
    check("arvalid_seen", seen, 1'b1);
    exp_a = q_addr.pop_front();
    exp_l = q_arlen.pop_front();
    if (!seen) begin
      burst_req = 1'b0; tail_req = 1'b0;
      return;
    end
    check("araddr", axi_bus.axi_araddr, exp_a);
    check("arlen", axi_bus.axi_arlen, exp_l);
    check("arsize", axi_bus.axi_arsize, 3'd5);
    check("arburst", axi_bus.axi_arburst, 2'b01);

    stable = 1'b1;
    repeat (ar_delay) begin
      tick();
      if (axi_bus.axi_araddr !== exp_a || axi_bus.axi_arlen !== exp_l || axi_bus.axi_arvalid !== 1'b1)
        stable = 1'b0;
    end
    if (ar_delay != 0) check("ar_stable", stable, 1'b1);

    axi_bus.axi_arready = 1'b1;
    tick();
    axi_bus.axi_arready = 1'b0;
    burst_req = 1'b0; tail_req = 1'b0;
    check("resp", resp, 1'b1);
    check("arvalid_drop", axi_bus.axi_arvalid, 1'b0);
    check("tail_status_post_ar", tail_status, exp_ts);
    check("tail_len_post_ar", tail_len, LSIZE'(exp_tl));
    if (fs_mid) frame_start = 1'b1;

    nbeats = (rlast_at != 0) ? rlast_at : len;
    b = 1; data_ok = 1'b1; cyc = 0;
    while (b <= nbeats && cyc < 4 * len + 20) begin
      axi_bus.axi_rvalid = 1'b1;
      axi_bus.axi_rdata  = {8{32'(b) ^ exp_a}};
      axi_bus.axi_rlast  = (b == nbeats);
      axi_bus.axi_rresp  = (b == slverr_beat) ? 2'b10 : 2'b00;
      fifo_full          = full_toggle && (cyc % 3 == 0);
      #1;
      if (fifo_wr_en) begin
        if (fifo_wdata !== axi_bus.axi_rdata) data_ok = 1'b0;
        b++;
      end
      @(posedge clock);
      #1;
      frame_start = 1'b0;
      cyc++;
      if (abort_at != 0 && b > abort_at) break;
    end

    if (abort_at != 0) begin
      rst = 1'b1;
      tick();
      check("abort_arvalid", axi_bus.axi_arvalid, 1'b0);
      check("abort_rready", axi_bus.axi_rready, 1'b0);
      check("abort_wr_en", fifo_wr_en, 1'b0);
      check("abort_resp_done", {resp, done}, 2'b00);
      check("abort_err", err, 1'b0);
      check("abort_tail_status", tail_status, 1'b0);
      rst = 1'b0;
      axi_bus.axi_rvalid = 1'b0;
      axi_bus.axi_rlast  = 1'b0;
      model_fs();
      tick();
      return;
    end

    axi_bus.axi_rvalid = 1'b0;
    axi_bus.axi_rlast  = 1'b0;
    axi_bus.axi_rresp  = 2'b00;
    fifo_full          = 1'b0;
    check("beats_accepted", b, nbeats + 1);
    check("done", done, 1'b1);
    check("fifo_wdata", data_ok, 1'b1);
    tick();
    check("done_pulse_end", done, 1'b0);
    check("done_count", done_total - dn0, 1);
    check("wr_count", wr_total - wr0, nbeats);
    check("tail_status_idle", tail_status, post_ts);
    check("tail_len_idle", tail_len, LSIZE'(post_tl));
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; burst_req = 1'b0; tail_req = 1'b0; req_len = '0;
    fifo_full = 1'b0;
    axi_bus.axi_arready = 1'b0; axi_bus.axi_rvalid = 1'b0; axi_bus.axi_rlast = 1'b0;
    axi_bus.axi_rresp = 2'b00; axi_bus.axi_rdata = '0;
    model_fs();
    repeat (3) tick();
    rst = 1'b0;
    check("rst_arvalid", axi_bus.axi_arvalid, 1'b0);
    check("rst_resp_done", {resp, done}, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_tail_status", tail_status, 1'b0);
    check("rst_rready", axi_bus.axi_rready, 1'b0);
    tick();

    // two normal bursts, the second with a slow arready and a stalling FIFO, then the tail
    run_burst(0, 200, 0, 0, 0, 0, 0, 0, 0);
    run_burst(0, 200, 10, 0, 0, 1, 0, 0, 0);
    check("tail_len_is_50", tail_len, 9'd50);
    run_burst(1, 50, 0, 0, 0, 0, 0, 0, 0);
    check("err_clean", err, 1'b0);

    // frame wrapped: next burst at BASE, rlast arrives early on beat 150
    run_burst(0, 200, 0, 150, 0, 0, 0, 0, 0);
    check("err_early_rlast", err, 1'b1);

    // reset mid-DATA after 5 beats
    run_burst(0, 200, 0, 0, 0, 0, 0, 0, 5);

    run_burst(0, 20, 2, 0, 5, 0, 0, 0, 0);
    check("err_slverr", err, 1'b1);

    // frame_start mid-burst, then the next burst must restart at BASE
    run_burst(0, 250, 0, 0, 0, 0, 1, 0, 0);
    run_burst(0, 16, 0, 0, 0, 0, 0, 0, 0);

    // zero-length request: resp and done together, no AR traffic
    burst_req = 1'b1; req_len = '0;
    tick();
    check("len0_resp_done", {resp, done}, 2'b11);
    check("len0_arvalid", axi_bus.axi_arvalid, 1'b0);
    burst_req = 1'b0;
    tick();
    check("len0_idle", {resp, done, axi_bus.axi_arvalid}, 3'b000);

    // frame_start coincident with a request in IDLE
    run_burst(0, 16, 0, 0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
